// File: rtl/vrf_wb_ctrl.sv
// Vector register file writeback controller: queues masked writebacks and turns partial
// masks into read-modify-write sequences. Define VRF_WB_BYPASS_EN for same-cycle full-mask writes.
module vrf_wb_ctrl #(
    parameter int unsigned VREGS      = 32,
    parameter int unsigned ELEMENTS   = 4,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic                           clk_i,
    input  logic                           reset,
    input  logic                           req_valid_i,
    output logic                           req_ready_o,
    input  logic [$clog2(VREGS)-1:0]       req_addr_i,
    input  logic [ELEMENTS-1:0]            req_mask_i,
    input  logic [ELEMENTS*DATA_WIDTH-1:0] req_data_i,
    output logic [$clog2(VREGS)-1:0]       vrf_rd_addr_o,
    input  logic [ELEMENTS*DATA_WIDTH-1:0] vrf_rd_data_i,
    output logic [ELEMENTS-1:0]            vrf_wr_en_o,
    output logic [$clog2(VREGS)-1:0]       vrf_wr_addr_o,
    output logic [ELEMENTS*DATA_WIDTH-1:0] vrf_wr_data_o,
    output logic                           busy_o,
    output logic                           done_o
);

    localparam int unsigned AW = $clog2(VREGS);
    localparam int unsigned LW = ELEMENTS * DATA_WIDTH;
    localparam int unsigned PW = $clog2(FIFO_DEPTH);

    localparam logic [ELEMENTS-1:0] MaskAll = {ELEMENTS{1'b1}};

    typedef enum logic [1:0] {
        StIdle,
        StWrite,
        StFetch,
        StMerge
    } state_e;

    state_e state_q, state_d;

    logic [AW-1:0]       fifo_addr [FIFO_DEPTH];
    logic [ELEMENTS-1:0] fifo_mask [FIFO_DEPTH];
    logic [LW-1:0]       fifo_data [FIFO_DEPTH];

    logic [PW-1:0] rd_ptr_q, wr_ptr_q;
    logic [PW:0]   count_q;

    logic                empty, full, push, pop, bypass;
    logic [AW-1:0]       head_addr;
    logic [ELEMENTS-1:0] head_mask;
    logic [LW-1:0]       head_data, merged;

    assign empty       = (count_q == '0);
    assign full        = (count_q == (PW+1)'(FIFO_DEPTH));
    assign req_ready_o = ~full & ~reset;
    assign busy_o      = ~empty | (state_q != StIdle);

    assign head_addr = fifo_addr[rd_ptr_q];
    assign head_mask = fifo_mask[rd_ptr_q];
    assign head_data = fifo_data[rd_ptr_q];

    always_comb begin
        merged = vrf_rd_data_i;
        for (int i = 0; i < ELEMENTS; i++) begin
            if (head_mask[i]) begin
                merged[i*DATA_WIDTH +: DATA_WIDTH] = head_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        vrf_rd_addr_o = '0;
        vrf_wr_en_o   = '0;
        vrf_wr_addr_o = '0;
        vrf_wr_data_o = '0;
        done_o        = 1'b0;
        pop           = 1'b0;
        bypass        = 1'b0;
        state_d       = state_q;

        unique case (state_q)
            StIdle: begin
                if (!empty) begin
                    if (head_mask == '0) begin
                        pop    = 1'b1;
                        done_o = 1'b1;
                    end
                end
`ifdef VRF_WB_BYPASS_EN
                else if (req_valid_i && req_ready_o && (req_mask_i == MaskAll)) begin
                    bypass        = 1'b1;
                    vrf_wr_en_o   = MaskAll;
                    vrf_wr_addr_o = req_addr_i;
                    vrf_wr_data_o = req_data_i;
                    done_o        = 1'b1;
                end
`endif
            end
            StWrite: begin
                vrf_wr_en_o   = MaskAll;
                vrf_wr_addr_o = head_addr;
                vrf_wr_data_o = head_data;
                pop           = 1'b1;
                done_o        = 1'b1;
                state_d       = StIdle;
            end
            StFetch: begin
                vrf_rd_addr_o = head_addr;
                state_d       = StMerge;
            end
            StMerge: begin
                vrf_wr_en_o   = MaskAll;
                vrf_wr_addr_o = head_addr;
                vrf_wr_data_o = merged;
                pop           = 1'b1;
                done_o        = 1'b1;
                state_d       = StIdle;
            end
            default: state_d = StIdle;
        endcase

        push = req_valid_i & req_ready_o & ~bypass;

        // An empty queue lets the incoming request steer IDLE so it is handled the next cycle.
        if (state_q == StIdle) begin
            if (!empty) begin
                if (head_mask == MaskAll) begin
                    state_d = StWrite;
                end else if (head_mask != '0) begin
                    state_d = StFetch;
                end
            end else if (push) begin
                if (req_mask_i == MaskAll) begin
                    state_d = StWrite;
                end else if (req_mask_i != '0) begin
                    state_d = StFetch;
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q <= state_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            if (push && !pop) begin
                count_q <= count_q + (PW+1)'(1);
            end else if (pop && !push) begin
                count_q <= count_q - (PW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_addr[wr_ptr_q] <= req_addr_i;
            fifo_mask[wr_ptr_q] <= req_mask_i;
            fifo_data[wr_ptr_q] <= req_data_i;
        end
    end

endmodule

// File: tb/tb_vrf_wb_ctrl.sv
// Directed bench for vrf_wb_ctrl with a behavioural one-cycle-latency VRF.
module tb_vrf_wb_ctrl;

    logic         clk_i = 1'b0;
    logic         reset = 1'b1;
    logic         req_valid_i = 1'b0;
    logic         req_ready_o;
    logic [4:0]   req_addr_i = '0;
    logic [3:0]   req_mask_i = '0;
    logic [127:0] req_data_i = '0;
    logic [4:0]   vrf_rd_addr_o;
    logic [127:0] vrf_rd_data_i;
    logic [3:0]   vrf_wr_en_o;
    logic [4:0]   vrf_wr_addr_o;
    logic [127:0] vrf_wr_data_o;
    logic         busy_o;
    logic         done_o;

    always #5 clk_i = ~clk_i;

    vrf_wb_ctrl dut (
        .clk_i        (clk_i),
        .reset        (reset),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_addr_i   (req_addr_i),
        .req_mask_i   (req_mask_i),
        .req_data_i   (req_data_i),
        .vrf_rd_addr_o(vrf_rd_addr_o),
        .vrf_rd_data_i(vrf_rd_data_i),
        .vrf_wr_en_o  (vrf_wr_en_o),
        .vrf_wr_addr_o(vrf_wr_addr_o),
        .vrf_wr_data_o(vrf_wr_data_o),
        .busy_o       (busy_o),
        .done_o       (done_o)
    );

    // Behavioural VRF; pl_* lets the bench preload a register.
    logic [127:0] mem [32];
    logic         pl_en = 1'b0;
    logic [4:0]   pl_addr = '0;
    logic [127:0] pl_data = '0;

    always @(posedge clk_i) begin
        if (pl_en) begin
            mem[pl_addr] <= pl_data;
        end else if (|vrf_wr_en_o) begin
            mem[vrf_wr_addr_o] <= vrf_wr_data_o;
        end
        vrf_rd_data_i <= mem[vrf_rd_addr_o];
    end

`ifdef VRF_WB_BYPASS_EN
    localparam int FULL_LAT = 0;
`else
    localparam int FULL_LAT = 1;
`endif

    typedef struct {
        logic [4:0]   addr;
        logic [3:0]   mask;
        logic [127:0] data;
        logic [127:0] pre;
        int           n_wr;
        logic [127:0] wdata;
        int           lat;
    } vec_t;

    vec_t vecs [6];

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int start;
    int done_n;
    int done_cyc;
    logic [127:0] wlog_data [$];
    logic [4:0]   wlog_addr [$];
    logic [3:0]   wlog_en [$];
    int           wlog_cyc [$];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic clear_logs();
        wlog_data.delete();
        wlog_addr.delete();
        wlog_en.delete();
        wlog_cyc.delete();
        done_n   = 0;
        done_cyc = -1;
    endtask

    // Called just after a falling edge: samples this cycle's outputs, then moves to the next one.
    task automatic sample_cycle();
        #2;
        if (|vrf_wr_en_o) begin
            wlog_data.push_back(vrf_wr_data_o);
            wlog_addr.push_back(vrf_wr_addr_o);
            wlog_en.push_back(vrf_wr_en_o);
            wlog_cyc.push_back(cyc);
        end
        if (done_o) begin
            if (done_n == 0) done_cyc = cyc;
            done_n++;
        end
        cyc++;
        @(negedge clk_i);
    endtask

    task automatic preload(input logic [4:0] a, input logic [127:0] d);
        pl_en   = 1'b1;
        pl_addr = a;
        pl_data = d;
        sample_cycle();
        pl_en = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{5'd3, 4'b1111, {4{32'hDDDDDDDD}}, 128'h0, 1, {4{32'hDDDDDDDD}}, FULL_LAT};
        vecs[1] = '{5'd5, 4'b0101, {4{32'hAAAAAAAA}},
                    {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111}, 1,
                    {32'h44444444, 32'hAAAAAAAA, 32'h22222222, 32'hAAAAAAAA}, 2};
        vecs[2] = '{5'd9, 4'b0000, {4{32'hFFFFFFFF}}, {4{32'h12345678}}, 0, 128'h0, 1};
        vecs[3] = '{5'd31, 4'b1000, {4{32'hBBBBBBBB}},
                    {32'h01234567, 32'h89ABCDEF, 32'hDEADBEEF, 32'hCAFEF00D}, 1,
                    {32'hBBBBBBBB, 32'h89ABCDEF, 32'hDEADBEEF, 32'hCAFEF00D}, 2};
        vecs[4] = '{5'd0, 4'b1110,
                    {32'hC4C4C4C4, 32'hC3C3C3C3, 32'hC2C2C2C2, 32'hC1C1C1C1},
                    {32'h0F0F0F0F, 32'h0E0E0E0E, 32'h0D0D0D0D, 32'h55555555}, 1,
                    {32'hC4C4C4C4, 32'hC3C3C3C3, 32'hC2C2C2C2, 32'h55555555}, 2};
        vecs[5] = '{5'd17, 4'b1111, {32'h4, 32'h3, 32'h2, 32'h1}, {4{32'h99999999}}, 1,
                    {32'h4, 32'h3, 32'h2, 32'h1}, FULL_LAT};

        // Reset state
        @(negedge clk_i);
        @(negedge clk_i);
        #1;
        chk("rst_ready", 128'(req_ready_o), 128'(0));
        chk("rst_busy", 128'(busy_o), 128'(0));
        chk("rst_wr_en", 128'(vrf_wr_en_o), 128'(0));
        chk("rst_done", 128'(done_o), 128'(0));
        chk("rst_rd_addr", 128'(vrf_rd_addr_o), 128'(0));
        @(negedge clk_i);
        reset = 1'b0;
        #1;
        chk("ready_after_reset", 128'(req_ready_o), 128'(1));

        // Single-request vectors, each started from an idle controller
        for (int v = 0; v < 6; v++) begin
            preload(vecs[v].addr, vecs[v].pre);
            clear_logs();
            req_valid_i = 1'b1;
            req_addr_i  = vecs[v].addr;
            req_mask_i  = vecs[v].mask;
            req_data_i  = vecs[v].data;
            start       = cyc;
            #1;
            chk($sformatf("v%0d_ready", v), 128'(req_ready_o), 128'(1));
            sample_cycle();
            req_valid_i = 1'b0;
            repeat (6) sample_cycle();
            chk($sformatf("v%0d_n_wr", v), 128'(wlog_data.size()), 128'(vecs[v].n_wr));
            chk($sformatf("v%0d_done_n", v), 128'(done_n), 128'(1));
            chk($sformatf("v%0d_done_lat", v), 128'(done_cyc - start), 128'(vecs[v].lat));
            chk($sformatf("v%0d_idle", v), 128'(busy_o), 128'(0));
            if (vecs[v].n_wr != 0 && wlog_data.size() != 0) begin
                chk($sformatf("v%0d_wr_lat", v), 128'(wlog_cyc[0] - start), 128'(vecs[v].lat));
                chk($sformatf("v%0d_wr_addr", v), 128'(wlog_addr[0]), 128'(vecs[v].addr));
                chk($sformatf("v%0d_wr_en", v), 128'(wlog_en[0]), 128'(4'b1111));
                chk($sformatf("v%0d_wr_data", v), wlog_data[0], vecs[v].wdata);
            end
        end

        // Back-to-back partial writes to r7: second merge must see the first's element 0
        preload(5'd7, {32'h40404040, 32'h30303030, 32'h20202020, 32'h10101010});
        clear_logs();
        req_valid_i = 1'b1;
        req_addr_i  = 5'd7;
        req_mask_i  = 4'b0001;
        req_data_i  = {4{32'hE1E1E1E1}};
        sample_cycle();
        req_mask_i  = 4'b0010;
        req_data_i  = {4{32'hE2E2E2E2}};
        #1;
        chk("b2b_ready", 128'(req_ready_o), 128'(1));
        sample_cycle();
        req_valid_i = 1'b0;
        repeat (10) sample_cycle();
        chk("b2b_n_wr", 128'(wlog_data.size()), 128'(2));
        chk("b2b_done_n", 128'(done_n), 128'(2));
        if (wlog_data.size() >= 2) begin
            chk("b2b_first", wlog_data[0],
                {32'h40404040, 32'h30303030, 32'h20202020, 32'hE1E1E1E1});
            chk("b2b_second", wlog_data[1],
                {32'h40404040, 32'h30303030, 32'hE2E2E2E2, 32'hE1E1E1E1});
            chk("b2b_addr", 128'(wlog_addr[1]), 128'(7));
        end

        // Fill the two-entry queue with partial requests
        clear_logs();
        req_valid_i = 1'b1;
        req_addr_i  = 5'd20;
        req_mask_i  = 4'b0011;
        req_data_i  = {4{32'h5A5A5A5A}};
        sample_cycle();
        req_addr_i = 5'd21;
        sample_cycle();
        req_addr_i = 5'd22;
        #1;
        chk("full_ready", 128'(req_ready_o), 128'(0));
        chk("full_busy", 128'(busy_o), 128'(1));
        sample_cycle();
        req_valid_i = 1'b0;
        #1;
        chk("after_retire_ready", 128'(req_ready_o), 128'(1));
        repeat (10) sample_cycle();
        chk("full_done_n", 128'(done_n), 128'(2));
        chk("full_drained", 128'(busy_o), 128'(0));

        // Reset while the first of two queued partial requests is in MERGE
        preload(5'd12, {4{32'h0BADF00D}});
        clear_logs();
        req_valid_i = 1'b1;
        req_addr_i  = 5'd12;
        req_mask_i  = 4'b0001;
        req_data_i  = {4{32'h77777777}};
        sample_cycle();
        req_addr_i = 5'd13;
        sample_cycle();
        req_valid_i = 1'b0;
        #1;
        chk("merge_reached", 128'(vrf_wr_en_o), 128'(4'b1111));
        reset = 1'b1;
        #1;
        chk("rstm_wr_en", 128'(vrf_wr_en_o), 128'(0));
        chk("rstm_busy", 128'(busy_o), 128'(0));
        chk("rstm_done", 128'(done_o), 128'(0));
        clear_logs();
        sample_cycle();
        reset = 1'b0;
        repeat (8) sample_cycle();
        chk("rstm_no_writes", 128'(wlog_data.size()), 128'(0));
        chk("rstm_no_done", 128'(done_n), 128'(0));
        chk("rstm_idle", 128'(busy_o), 128'(0));
        chk("rstm_r12_kept", mem[12], {4{32'h0BADF00D}});

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
